// File: rtl/pos_cell_pkg.sv
// pos_cell_pkg
// Definitions shared by the position cell access controller and the
// position cache that sits behind it:
//   cell_state_t    - sequencer states of the access controller
//   COUNT_LSB       - bit position of the particle count inside word 0
//   CNT_WAIT_CYCLES - cycles spent waiting for the count word
//   CELL_RD_LAT     - read latency of the cell RAM (mem_rden -> mem_q)
package pos_cell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_REQ,
        ST_CNT_WAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } cell_state_t;

    localparam int COUNT_LSB       = 0;
    localparam int CNT_WAIT_CYCLES = 2;
    localparam int CELL_RD_LAT     = 2;

endpackage

// File: rtl/pos_cell_tag_pipe.sv
// pos_cell_tag_pipe
// Delay line that carries {valid, id} alongside an in-flight RAM read so the
// tag emerges in the same cycle as the read data.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high clear of every stage
//   in_valid  in   a tagged read is issued this cycle
//   in_id     in   address of that read
//   out_valid out  tag valid in the last stage (aligned with RAM data)
//   out_id    out  id in the last stage
//   pending   out  a valid tag sits in any stage before the last one
module pos_cell_tag_pipe
    import pos_cell_pkg::*;
#(
    parameter int ID_WIDTH = 8,
    parameter int STAGES   = CELL_RD_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    output logic [ID_WIDTH-1:0] out_id,
    output logic                pending
);

    logic                vld_p [STAGES];
    logic [ID_WIDTH-1:0] id_p  [STAGES];

    // stage 0 takes the issued tag, later stages shift it toward the output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i] <= 1'b0;
                id_p[i]  <= '0;
            end
        end else begin
            vld_p[0] <= in_valid;
            id_p[0]  <= in_id;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                id_p[i]  <= id_p[i-1];
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_id    = id_p[STAGES-1];

    // The last stage is excluded: once only it is occupied the pipe will be
    // empty on the next cycle, which lets the drain finish without a bubble.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            pending = pending | vld_p[i];
        end
    end

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// pos_cell_access_ctrl
// Sequencer and arbiter for one single-port position cell RAM. On rd_start it
// reads the particle count from address 0, then streams addresses 1..count
// out with their ids. Motion-update writes share the RAM port and win over
// stream reads; they are only held off while the count read is issued.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rd_start                     stream request (accepted in IDLE only)
//   rd_busy, rd_done             stream in progress / completion pulse
//   rd_particle_num              latched, clamped particle count
//   rd_data_valid, rd_data,
//   rd_particle_id               streamed particle word and its address
//   wr_req, wr_addr, wr_data     write-back request, held until wr_gnt
//   wr_gnt                       write performed this cycle
//   mem_address, mem_data,
//   mem_rden, mem_wren, mem_q    cell RAM port
module pos_cell_access_ctrl
    import pos_cell_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [ADDR_WIDTH-1:0] rd_particle_num,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_particle_id,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int                    WAIT_W    = $clog2(CNT_WAIT_CYCLES + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(CNT_WAIT_CYCLES - 1);

    // A corrupt or oversized count must never drive reads past the RAM end.
    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_COUNT) ? MAX_COUNT : raw;
    endfunction

    cell_state_t           state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] count_clamped;
    logic                  cnt_issue;
    logic                  stream_issue;
    logic                  tag_pending;

    assign count_clamped = clamp_count(mem_q[COUNT_LSB +: ADDR_WIDTH]);

    // Arbitration: writes win everywhere except while the count read goes out.
    assign wr_gnt       = wr_req && (state != ST_CNT_REQ);
    assign cnt_issue    = (state == ST_CNT_REQ);
    assign stream_issue = (state == ST_STREAM) && !wr_gnt;

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        if (wr_gnt) begin
            mem_wren    = 1'b1;
            mem_address = wr_addr;
            mem_data    = wr_data;
        end else if (cnt_issue) begin
            mem_rden    = 1'b1;
        end else if (stream_issue) begin
            mem_rden    = 1'b1;
            mem_address = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            ptr             <= ADDR_WIDTH'(1);
            rd_particle_num <= '0;
            rd_busy         <= 1'b0;
            rd_done         <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        state   <= ST_CNT_REQ;
                        rd_busy <= 1'b1;
                    end
                end
                ST_CNT_REQ: begin
                    state    <= ST_CNT_WAIT;
                    wait_cnt <= '0;
                end
                ST_CNT_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        rd_particle_num <= count_clamped;
                        ptr             <= ADDR_WIDTH'(1);
                        state           <= (count_clamped == '0) ? ST_DRAIN : ST_STREAM;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    // a granted write stalls the pointer for this cycle
                    if (stream_issue) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == rd_particle_num) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!tag_pending) begin
                        state   <= ST_DONE;
                        rd_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    rd_busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Only stream reads are tagged; the count read never reaches rd_data_valid.
    pos_cell_tag_pipe #(
        .ID_WIDTH (ADDR_WIDTH),
        .STAGES   (CELL_RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (stream_issue),
        .in_id     (ptr),
        .out_valid (rd_data_valid),
        .out_id    (rd_particle_id),
        .pending   (tag_pending)
    );

    assign rd_data = mem_q;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
module tb_pos_cell_access_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start;
    logic          rd_busy;
    logic          rd_done;
    logic [AW-1:0] rd_particle_num;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_particle_id;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    // RAM model with a bench-side preload port
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] ram [256];
    logic [DW-1:0] q_p1;
    logic [DW-1:0] shadow [256];

    typedef struct {
        int            cyc;
        logic [AW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    pos_cell_access_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (PN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_start        (rd_start),
        .rd_busy         (rd_busy),
        .rd_done         (rd_done),
        .rd_particle_num (rd_particle_num),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .rd_particle_id  (rd_particle_id),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_gnt          (wr_gnt),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_rden        (mem_rden),
        .mem_wren        (mem_wren),
        .mem_q           (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) q_p1 <= ram[mem_address];
        mem_q <= q_p1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 128'(rd_particle_id), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", 128'(cyc), 128'(e.cyc));
                check("rd_particle_id", 128'(rd_particle_id), 128'(e.id));
                check("rd_data", 128'(rd_data), 128'(e.data));
                check("busy_with_valid", 128'(rd_busy), 128'(1));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = d;
        shadow[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Model of stream timing: reads from cycle 4, one per cycle, skipping
    // cycles with a STREAM write grant (bits of gmask); data 2 cycles later.
    task automatic push_expected(input int s, input int n, input logic [63:0] gmask,
                                 input int keep, output int done_rel);
        int c;
        int k;
        int last;
        c = 4;
        k = 1;
        last = 3;
        while (k <= n) begin
            if (c < 64 && gmask[c]) begin
                c++;
            end else begin
                if (k <= keep) sb.push_back('{s + c + 2, AW'(k), shadow[k]});
                last = c;
                k++;
                c++;
            end
        end
        done_rel = (n == 0) ? 5 : last + 3;
    endtask

    task automatic start_stream(output int s);
        next_cycle();
        s = cyc;
        rd_start = 1'b1;
        next_cycle();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input int s, input int exp_rel, input string tag);
        int got;
        got = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (rd_done === 1'b1) begin
                got = cyc - s;
                break;
            end
        end
        check({tag, "_done_cycle"}, 128'(got), 128'(exp_rel));
        check({tag, "_busy_at_done"}, 128'(rd_busy), 128'(1));
        @(negedge clk);
        check({tag, "_busy_after"}, 128'(rd_busy), 128'(0));
        check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(rd_busy), 128'(0));
        check({tag, "_done"}, 128'(rd_done), 128'(0));
        check({tag, "_valid"}, 128'(rd_data_valid), 128'(0));
        check({tag, "_num"}, 128'(rd_particle_num), 128'(0));
        check({tag, "_id"}, 128'(rd_particle_id), 128'(0));
        check({tag, "_rden"}, 128'(mem_rden), 128'(0));
        check({tag, "_wren"}, 128'(mem_wren), 128'(0));
        check({tag, "_addr"}, 128'(mem_address), 128'(0));
        check({tag, "_mdata"}, 128'(mem_data), 128'(0));
        check({tag, "_gnt"}, 128'(wr_gnt), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int done_rel;
        logic [DW-1:0] d;
        rst = 1'b1;
        rd_start = 1'b0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;

        // reset state
        repeat (2) next_cycle();
        @(negedge clk);
        check_all_zero("reset");

        // a write request in IDLE is granted even while reset is held
        next_cycle();
        d = {$urandom, $urandom, $urandom};
        wr_req = 1'b1;
        wr_addr = 8'd200;
        wr_data = d;
        shadow[200] = d;
        @(negedge clk);
        check("idle_wr_gnt", 128'(wr_gnt), 128'(1));
        check("idle_wr_wren", 128'(mem_wren), 128'(1));
        check("idle_wr_addr", 128'(mem_address), 128'(200));
        check("idle_wr_data", 128'(mem_data), 128'(d));
        check("idle_wr_rden", 128'(mem_rden), 128'(0));
        next_cycle();
        wr_req = 1'b0;
        rst = 1'b0;

        for (int a = 1; a < PN; a++) preload(a, {$urandom, $urandom, $urandom});
        preload(0, 96'd5);

        // count 5, plain stream; a stray rd_start mid-stream is ignored
        start_stream(s);
        push_expected(s, 5, 64'd0, 5, done_rel);
        @(negedge clk);
        check("t1_busy_c1", 128'(rd_busy), 128'(1));
        check("t1_rden_c1", 128'(mem_rden), 128'(1));
        check("t1_addr_c1", 128'(mem_address), 128'(0));
        repeat (4) next_cycle();
        rd_start = 1'b1;
        next_cycle();
        rd_start = 1'b0;
        wait_done(s, done_rel, "t1");
        check("t1_num", 128'(rd_particle_num), 128'(5));
        check("t1_idle_busy", 128'(rd_busy), 128'(0));

        // write to address 3 requested during the count read, granted a cycle later
        start_stream(s);
        d = {$urandom, $urandom, $urandom};
        wr_req = 1'b1;
        wr_addr = 8'd3;
        wr_data = d;
        shadow[3] = d;
        push_expected(s, 5, 64'd0, 5, done_rel);
        @(negedge clk);
        check("t2_gnt_c1", 128'(wr_gnt), 128'(0));
        check("t2_rden_c1", 128'(mem_rden), 128'(1));
        next_cycle();
        @(negedge clk);
        check("t2_gnt_c2", 128'(wr_gnt), 128'(1));
        check("t2_wren_c2", 128'(mem_wren), 128'(1));
        check("t2_addr_c2", 128'(mem_address), 128'(3));
        check("t2_rden_c2", 128'(mem_rden), 128'(0));
        next_cycle();
        wr_req = 1'b0;
        wait_done(s, done_rel, "t2");

        // three back-to-back grants during STREAM (cycles 5..7) to address 4
        start_stream(s);
        d = {$urandom, $urandom, $urandom};
        shadow[4] = d;
        push_expected(s, 5, 64'h0000_0000_0000_00E0, 5, done_rel);
        repeat (4) next_cycle();
        for (int g = 0; g < 3; g++) begin
            wr_req = 1'b1;
            wr_addr = 8'd4;
            wr_data = (g == 2) ? d : {$urandom, $urandom, $urandom};
            @(negedge clk);
            check("t3_gnt", 128'(wr_gnt), 128'(1));
            check("t3_no_rden", 128'(mem_rden), 128'(0));
            next_cycle();
        end
        wr_req = 1'b0;
        wait_done(s, done_rel, "t3");
        check("t3_done_rel", 128'(done_rel), 128'(14));

        // count 0: straight to drain, no data
        preload(0, 96'd0);
        start_stream(s);
        push_expected(s, 0, 64'd0, 0, done_rel);
        wait_done(s, done_rel, "t4");
        check("t4_num", 128'(rd_particle_num), 128'(0));

        // count 250 clamps to PARTICLE_NUM-1
        preload(0, 96'd250);
        start_stream(s);
        push_expected(s, PN - 1, 64'd0, PN - 1, done_rel);
        wait_done(s, done_rel, "t5");
        check("t5_num", 128'(rd_particle_num), 128'(PN - 1));

        // reset at cycle 7 of a stream discards in-flight reads
        preload(0, 96'd5);
        start_stream(s);
        push_expected(s, 5, 64'd0, 2, done_rel);
        repeat (6) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_cycle", 128'(cyc - s), 128'(8));
        check_all_zero("t6");
        repeat (6) next_cycle();
        check("t6_sb_empty", 128'(sb.size()), 128'(0));

        // normal stream after the mid-operation reset
        start_stream(s);
        push_expected(s, 5, 64'd0, 5, done_rel);
        wait_done(s, done_rel, "t7");
        check("t7_num", 128'(rd_particle_num), 128'(5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
